// File: rtl/serial_rx_controller.sv
// Receive-side serial controller: shifts NBITS data bits (MSB first) into a word and presents it on valid/ready.
// Optional even-parity bit after the data bits when PARITY_RX_EN is defined.
module serial_rx_controller #(
  parameter int NBITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       bit_en,
  input  logic                       rx_bit,
  input  logic                       word_ready,
  output logic [NBITS-1:0]           word,
  output logic                       word_valid,
  output logic                       busy,
  output logic [$clog2(NBITS+1)-1:0] bit_cnt,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int CW = $clog2(NBITS+1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] sreg;
  logic             last_bit;

  assign last_bit = (bit_cnt == CW'(NBITS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = SHIFT;
      SHIFT: begin
        if (bit_en && last_bit) begin
`ifdef PARITY_RX_EN
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end
      end
      PARITY: if (bit_en) state_nxt = DONE;
      DONE:   if (word_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start cycle only clears; data is taken exclusively from SHIFT-state strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            sreg    <= {sreg[NBITS-2:0], rx_bit};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PARITY_RX_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          parity_err <= 1'b0;
    else if (state == IDLE && start)    parity_err <= 1'b0;
    else if (state == PARITY && bit_en) parity_err <= ^{sreg, rx_bit};
  end
`else
  assign parity_err = 1'b0;
`endif

  assign word       = sreg;
  assign word_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign overrun    = start && (state != IDLE);

endmodule

// File: tb/tb_serial_rx_controller.sv
// Randomized self-checking bench for serial_rx_controller; reference model works on bit queues and arithmetic.
module tb_serial_rx_controller;

  localparam int N  = 4;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start, bit_en, rx_bit, word_ready;
  logic [N-1:0]  word;
  logic          word_valid, busy, overrun, parity_err;
  logic [CW-1:0] bit_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  serial_rx_controller #(.NBITS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .bit_en(bit_en), .rx_bit(rx_bit),
    .word_ready(word_ready), .word(word), .word_valid(word_valid), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Combinational outputs checked mid-cycle, then advance to just after the next edge.
  task automatic tick(input logic exp_ovr, input logic exp_vld);
    @(negedge clk);
    check("overrun", overrun, exp_ovr);
    check("word_valid", word_valid, exp_vld);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, word, 0);
    check({tag, "_valid"}, word_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bit_cnt"}, bit_cnt, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_parity_err"}, parity_err, 0);
  endtask

  // Idle bit-time cycles: rx_bit toggles randomly, stray starts must only raise overrun.
  task automatic gap(input int lo, input int hi, input int exp_cnt);
    int  n;
    logic s;
    n = $urandom_range(hi, lo);
    for (int g = 0; g < n; g++) begin
      s      = ($urandom % 4 == 0);
      start  = s;
      bit_en = 1'b0;
      rx_bit = 1'($urandom);
      tick(s, 1'b0);
      start  = 1'b0;
      check("gap_bit_cnt", bit_cnt, exp_cnt);
    end
  endtask

  task automatic rx_word(input logic [N-1:0] w, input logic par, input int lo, input int hi,
                         input int hold, input bit directed, input bit en_on_start);
    bit          q[$];
    int unsigned exp_w;
    int          ones;
    int          exp_pe;
    logic        s;
    for (int i = N - 1; i >= 0; i--) q.push_back(w[i]);

    start  = 1'b1;
    bit_en = en_on_start;
    rx_bit = 1'($urandom);
    tick(1'b0, 1'b0);
    start  = 1'b0;
    bit_en = 1'b0;
    check("start_bit_cnt", bit_cnt, 0);
    check("start_word", word, 0);
    check("start_busy", busy, 1);
    check("start_parity_err", parity_err, 0);

    exp_w = 0;
    ones  = 0;
    for (int i = 0; i < N; i++) begin
      gap(lo, hi, i);
      bit_en = 1'b1;
      rx_bit = q[i];
      tick(1'b0, 1'b0);
      bit_en = 1'b0;
      exp_w  = exp_w * 2 + q[i];
      ones  += q[i];
      check("shift_bit_cnt", bit_cnt, i + 1);
    end

`ifdef PARITY_RX_EN
    gap(lo, hi, N);
    bit_en = 1'b1;
    rx_bit = par;
    tick(1'b0, 1'b0);
    bit_en = 1'b0;
    exp_pe = (ones + int'(par)) % 2;
`else
    exp_pe = 0;
`endif

    check("done_valid", word_valid, 1);
    check("done_word", word, exp_w);
    check("done_parity_err", parity_err, exp_pe);
    check("done_busy", busy, 1);
    check("done_bit_cnt", bit_cnt, N);

    for (int k = 0; k < hold; k++) begin
      s          = directed ? (k == 1 || k == 4) : ($urandom % 3 == 0);
      start      = s;
      bit_en     = 1'($urandom);
      rx_bit     = 1'($urandom);
      word_ready = 1'b0;
      tick(s, 1'b1);
      start      = 1'b0;
      check("hold_word", word, exp_w);
      check("hold_busy", busy, 1);
    end

    s          = 1'($urandom);
    start      = s;
    word_ready = 1'b1;
    bit_en     = 1'($urandom);
    tick(s, 1'b1);
    start      = 1'b0;
    word_ready = 1'b0;
    bit_en     = 1'b0;
    check("idle_valid", word_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_word", word, exp_w);
    check("idle_parity_err", parity_err, exp_pe);
    check("idle_bit_cnt", bit_cnt, N);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bit_en = 1'b0; rx_bit = 1'b0; word_ready = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-word discards the partial word immediately.
    start = 1'b1; tick(1'b0, 1'b0); start = 1'b0;
    bit_en = 1'b1; rx_bit = 1'b1; tick(1'b0, 1'b0);
    rx_bit = 1'b1; tick(1'b0, 1'b0); bit_en = 1'b0;
    check("pre_reset_bit_cnt", bit_cnt, 2);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    rx_word(4'b0110, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    rx_word(4'b1011, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    rx_word(4'b1101, 1'b1, 1, 3, 1, 1'b0, 1'b0);
    rx_word(4'b0101, 1'b0, 0, 1, 6, 1'b1, 1'b0);
    rx_word(4'b0011, 1'b0, 0, 0, 0, 1'b0, 1'b1);
`ifdef PARITY_RX_EN
    rx_word(4'b1011, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    rx_word(4'b1011, 1'b0, 0, 0, 0, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 30; t++)
      rx_word(N'($urandom), 1'($urandom), 0, 2, $urandom_range(3, 0), 1'b0, 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
